// File: rtl/mem_copy_engine.sv
// Memory-to-memory byte copy engine driving the data-memory port while busy.
// Optional fill mode (write fill_val without reading) is enabled by MEMCPY_FILL_EN.
module mem_copy_engine (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] src_addr,
   input  logic [7:0] dst_addr,
   input  logic [7:0] len,
   input  logic       fill,
   input  logic [7:0] fill_val,
   output logic       busy,
   output logic       done,
   output logic [7:0] remaining,
   output logic [7:0] DataAddress,
   output logic       ReadMem,
   output logic       WriteMem,
   output logic [7:0] DataIn,
   input  logic [7:0] DataOut
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t     state_q;
   logic [7:0] sp_q, dp_q, rem_q, addr_q, din_q;
   logic       busy_q, done_q, rd_q, wr_q;
   logic [7:0] sp_d, dp_d, rem_d;

   logic       fill_acc;   // fill requested on the accept cycle
   logic [7:0] fill_acc_val;
   logic       fill_mode;  // latched fill mode for the running transfer
   logic [7:0] fill_byte;

`ifdef MEMCPY_FILL_EN
   logic       fill_q;
   logic [7:0] fval_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fill_q <= 1'b0;
         fval_q <= '0;
      end else if (state_q == IDLE && start) begin
         fill_q <= fill;
         fval_q <= fill_val;
      end
   end

   always_comb begin
      fill_acc     = fill;
      fill_acc_val = fill_val;
      fill_mode    = fill_q;
      fill_byte    = fval_q;
   end
`else
   logic unused_fill;
   assign unused_fill = ^{fill, fill_val};

   always_comb begin
      fill_acc     = 1'b0;
      fill_acc_val = '0;
      fill_mode    = 1'b0;
      fill_byte    = '0;
   end
`endif

   always_comb begin
      sp_d  = sp_q + 8'd1;
      dp_d  = dp_q + 8'd1;
      rem_d = rem_q - 8'd1;
   end

   // Outputs are loaded with the decode of the state being entered, so they
   // are valid from the first instant of each cycle. din_q doubles as the hold
   // register: the byte read in READ is exactly what WRITE drives.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sp_q    <= '0;
         dp_q    <= '0;
         rem_q   <= '0;
         addr_q  <= '0;
         din_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  sp_q  <= src_addr;
                  dp_q  <= dst_addr;
                  rem_q <= len;
                  if (len == 8'd0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else if (fill_acc) begin
                     state_q <= WRITE;
                     busy_q  <= 1'b1;
                     addr_q  <= dst_addr;
                     wr_q    <= 1'b1;
                     din_q   <= fill_acc_val;
                  end else begin
                     state_q <= READ;
                     busy_q  <= 1'b1;
                     addr_q  <= src_addr;
                     rd_q    <= 1'b1;
                  end
               end
            end
            READ: begin
               state_q <= WRITE;
               sp_q    <= sp_d;
               addr_q  <= dp_q;
               rd_q    <= 1'b0;
               wr_q    <= 1'b1;
               din_q   <= DataOut;
            end
            WRITE: begin
               dp_q  <= dp_d;
               rem_q <= rem_d;
               if (rem_q == 8'd1) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  addr_q  <= '0;
                  wr_q    <= 1'b0;
                  din_q   <= '0;
               end else if (fill_mode) begin
                  addr_q <= dp_d;
                  din_q  <= fill_byte;
               end else begin
                  state_q <= READ;
                  addr_q  <= sp_q;
                  rd_q    <= 1'b1;
                  wr_q    <= 1'b0;
                  din_q   <= '0;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign remaining   = rem_q;
   assign DataAddress = addr_q;
   assign ReadMem     = rd_q;
   assign WriteMem    = wr_q;
   assign DataIn      = din_q;

endmodule
